// File: rtl/div_tick_ctrl_if.sv
// Bus between the clkdiv/game-logic side and div_tick_ctrl.
// master: tap config, control and ack; slave: the tick controller.
interface div_tick_ctrl_if #(
   parameter int unsigned DIV_W  = 32,
   parameter int unsigned SEL_W  = 5,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned MISS_W = 8
);
   logic [DIV_W-1:0]  clkdiv;
   logic [SEL_W-1:0]  tap_sel;
   logic              enable;
   logic              pause;
   logic              clr;
   logic              tick_ack;
   logic              tick_req;
   logic [CNT_W-1:0]  tick_cnt;
   logic [MISS_W-1:0] miss_cnt;

   modport master (
      output clkdiv, tap_sel, enable, pause, clr, tick_ack,
      input  tick_req, tick_cnt, miss_cnt
   );

   modport slave (
      input  clkdiv, tap_sel, enable, pause, clr, tick_ack,
      output tick_req, tick_cnt, miss_cnt
   );
endinterface

// File: rtl/div_tick_ctrl.sv
// Picks one clkdiv tap, turns its rising edges into held tick requests and counts ticks/misses.
// Build option TICK_MISS_SAT_EN: miss_cnt saturates instead of wrapping.
module div_tick_ctrl #(
   parameter int unsigned DIV_W  = 32,
   parameter int unsigned SEL_W  = 5,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned MISS_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   div_tick_ctrl_if.slave  bus
);
   localparam int unsigned EXT_W = 1 << SEL_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      PEND  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_tap_d;
   logic [SEL_W-1:0]   r_sel_d;
   logic               r_tick_req;
   logic [CNT_W-1:0]   r_tick_cnt;
   logic [MISS_W-1:0]  r_miss_cnt;

   logic [DIV_W-1:0]   w_clkdiv;
   logic [EXT_W-1:0]   w_div_ext;
   logic               w_tap;
   logic               w_sel_chg;
   logic               w_active;
   logic               w_rise;
   logic               w_tick_inc;
   logic               w_miss_inc;
   logic [MISS_W-1:0]  w_miss_nxt;

   // Taps at or above DIV_W read the zero-extended upper bits.
   assign w_clkdiv  = bus.clkdiv;
   assign w_div_ext = EXT_W'(w_clkdiv);
   assign w_tap     = w_div_ext[bus.tap_sel];

   assign w_sel_chg = (r_sel_d != bus.tap_sel);
   assign w_active  = (r_state == RUN) || (r_state == PEND);
   assign w_rise    = w_tap & ~r_tap_d & w_active & ~bus.pause
                      & bus.enable & ~w_sel_chg;

   // Next state and counter increments; disable beats tap change beats normal flow.
   always_comb begin
      w_state_nxt = r_state;
      w_tick_inc  = 1'b0;
      w_miss_inc  = 1'b0;
      if (!bus.enable) begin
         w_state_nxt = IDLE;
      end else if (w_sel_chg) begin
         w_state_nxt = PRIME;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = PRIME;
            end
            PRIME: begin
               w_state_nxt = RUN;
            end
            RUN: begin
               if (w_rise) begin
                  w_state_nxt = PEND;
                  w_tick_inc  = 1'b1;
               end
            end
            PEND: begin
               if (w_rise) begin
                  w_tick_inc = 1'b1;
                  w_miss_inc = ~bus.tick_ack;
               end else if (bus.tick_ack) begin
                  w_state_nxt = RUN;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

`ifdef TICK_MISS_SAT_EN
   assign w_miss_nxt = (&r_miss_cnt) ? r_miss_cnt : r_miss_cnt + MISS_W'(1);
`else
   assign w_miss_nxt = r_miss_cnt + MISS_W'(1);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Edge-detect history and registered request flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tap_d    <= 1'b0;
         r_sel_d    <= '0;
         r_tick_req <= 1'b0;
      end else begin
         r_tap_d    <= w_tap;
         r_sel_d    <= bus.tap_sel;
         r_tick_req <= (w_state_nxt == PEND);
      end
   end

   // Clear has priority over any same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
         r_miss_cnt <= '0;
      end else if (bus.clr) begin
         r_tick_cnt <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_tick_inc) begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
         end
         if (w_miss_inc) begin
            r_miss_cnt <= w_miss_nxt;
         end
      end
   end

   assign bus.tick_req = r_tick_req;
   assign bus.tick_cnt = r_tick_cnt;
   assign bus.miss_cnt = r_miss_cnt;
endmodule

// File: tb/tb_div_tick_ctrl.sv
// Directed bench for div_tick_ctrl; clkdiv is a bench-side counter advanced after every edge.
// Expectations are derived from edge index k, where edge k samples the clkdiv value set before it.
module tb_div_tick_ctrl;
   localparam int unsigned DIV_W  = 32;
   localparam int unsigned SEL_W  = 5;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned MISS_W = 8;

   logic clk = 1'b0;
   logic rst;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   div_tick_ctrl_if #(.DIV_W(DIV_W), .SEL_W(SEL_W), .CNT_W(CNT_W), .MISS_W(MISS_W)) bus ();

   div_tick_ctrl #(.DIV_W(DIV_W), .SEL_W(SEL_W), .CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // One clock: outputs are sampled 1 ns after the edge, then clkdiv advances.
   task automatic tick();
      @(posedge clk);
      #1;
      bus.clkdiv = bus.clkdiv + DIV_W'(1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.clkdiv = '0; bus.tap_sel = '0; bus.enable = 1'b0; bus.pause = 1'b0;
      bus.clr = 1'b0; bus.tick_ack = 1'b0;
      repeat (3) tick();
      n_vec++;
      if (bus.tick_req !== 1'b0 || bus.tick_cnt !== CNT_W'(0) || bus.miss_cnt !== MISS_W'(0)) begin
         n_err++;
         $display("FAIL reset_hold req=%b cnt=%0d miss=%0d required 0/0/0",
                  bus.tick_req, bus.tick_cnt, bus.miss_cnt);
      end
      rst = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick();
         n_vec++;
         if (bus.tick_req !== 1'b0 || bus.tick_cnt !== CNT_W'(0) || bus.miss_cnt !== MISS_W'(0)) begin
            n_err++;
            $display("FAIL idle_disabled k=%0d req=%b cnt=%0d miss=%0d required 0/0/0",
                     k, bus.tick_req, bus.tick_cnt, bus.miss_cnt);
         end
      end
   endtask

   // tap 3: rise when clkdiv goes 7->8, i.e. every edge with k%16==8; acked the next cycle.
   task automatic test_tick_stream();
      logic exp_req;
      bus.clkdiv = '0; bus.tap_sel = SEL_W'(3); bus.enable = 1'b1; bus.tick_ack = 1'b0;
      for (int k = 0; k < 160; k++) begin
         tick();
         exp_req = ((k % 16) == 8);
         n_vec++;
         if (bus.tick_req !== exp_req) begin
            n_err++;
            $display("FAIL stream_req k=%0d got=%b exp=%b", k, bus.tick_req, exp_req);
         end
         bus.tick_ack = exp_req;
      end
      n_vec++;
      if (bus.tick_cnt !== CNT_W'(10) || bus.miss_cnt !== MISS_W'(0)) begin
         n_err++;
         $display("FAIL stream_counts cnt=%0d miss=%0d required 10/0", bus.tick_cnt, bus.miss_cnt);
      end
   endtask

   // tap 2 with no ack for 40 edges: rises at k=4,12,20,28,36.
   task automatic test_miss_hold();
      logic exp_req;
      bus.clkdiv = '0; bus.tap_sel = SEL_W'(2); bus.clr = 1'b1; bus.tick_ack = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (k == 0) begin
            bus.clr = 1'b0;
            n_vec++;
            if (bus.tick_cnt !== CNT_W'(0)) begin
               n_err++;
               $display("FAIL hold_clr cnt=%0d required 0", bus.tick_cnt);
            end
         end
         exp_req = (k >= 4);
         n_vec++;
         if (bus.tick_req !== exp_req) begin
            n_err++;
            $display("FAIL hold_req k=%0d got=%b exp=%b", k, bus.tick_req, exp_req);
         end
      end
      n_vec++;
      if (bus.tick_cnt !== CNT_W'(5) || bus.miss_cnt !== MISS_W'(4)) begin
         n_err++;
         $display("FAIL hold_counts cnt=%0d miss=%0d required 5/4", bus.tick_cnt, bus.miss_cnt);
      end
      bus.tick_ack = 1'b1;
      tick();
      bus.tick_ack = 1'b0;
      n_vec++;
      if (bus.tick_req !== 1'b0) begin
         n_err++;
         $display("FAIL hold_ack_drop req=%b required 0", bus.tick_req);
      end
   endtask

   // Continues the tap-2 run: rise at edge 44 (new tick), ack coincides with rise at edge 52.
   task automatic test_ack_on_rise();
      for (int j = 41; j <= 52; j++) begin
         bus.tick_ack = (j == 52);
         tick();
         if (j == 44) begin
            n_vec++;
            if (bus.tick_req !== 1'b1 || bus.tick_cnt !== CNT_W'(6)) begin
               n_err++;
               $display("FAIL ackrise_pre req=%b cnt=%0d required 1/6", bus.tick_req, bus.tick_cnt);
            end
         end
      end
      bus.tick_ack = 1'b0;
      n_vec++;
      if (bus.tick_req !== 1'b1 || bus.tick_cnt !== CNT_W'(7) || bus.miss_cnt !== MISS_W'(4)) begin
         n_err++;
         $display("FAIL ackrise_post req=%b cnt=%0d miss=%0d required 1/7/4",
                  bus.tick_req, bus.tick_cnt, bus.miss_cnt);
      end
   endtask

   // Pending on tap 3, then switch to tap 5 while clkdiv[5]=1; next rise is clkdiv 95->96.
   task automatic test_sel_change();
      logic             exp_req;
      logic [CNT_W-1:0] exp_cnt;
      bus.clkdiv = '0; bus.tap_sel = SEL_W'(3); bus.clr = 1'b1; bus.tick_ack = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         tick();
         if (k == 0) bus.clr = 1'b0;
      end
      n_vec++;
      if (bus.tick_req !== 1'b1 || bus.tick_cnt !== CNT_W'(1)) begin
         n_err++;
         $display("FAIL selchg_setup req=%b cnt=%0d required 1/1", bus.tick_req, bus.tick_cnt);
      end
      bus.tap_sel = SEL_W'(5);
      bus.clkdiv  = DIV_W'(32);
      for (int k = 0; k <= 65; k++) begin
         tick();
         exp_req = (k == 64);
         exp_cnt = (k >= 64) ? CNT_W'(2) : CNT_W'(1);
         n_vec++;
         if (bus.tick_req !== exp_req || bus.tick_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL selchg k=%0d req=%b cnt=%0d exp=%b/%0d",
                     k, bus.tick_req, bus.tick_cnt, exp_req, exp_cnt);
         end
         bus.tick_ack = ((k >= 1) && (k < 63)) || (k == 64);
      end
      n_vec++;
      if (bus.miss_cnt !== MISS_W'(0)) begin
         n_err++;
         $display("FAIL selchg_miss got=%0d required 0", bus.miss_cnt);
      end
   endtask

   // tap 0 toggles every cycle: pause masks rises at 5,7,9 and ack works while paused; then disable.
   task automatic test_pause_enable();
      logic             exp_req;
      logic [CNT_W-1:0] exp_cnt;
      bus.clkdiv = '0; bus.tap_sel = SEL_W'(0); bus.clr = 1'b1; bus.tick_ack = 1'b0;
      for (int k = 0; k <= 11; k++) begin
         tick();
         exp_req = ((k >= 3) && (k <= 7)) || (k == 11);
         exp_cnt = (k < 3) ? CNT_W'(0) : ((k < 11) ? CNT_W'(1) : CNT_W'(2));
         n_vec++;
         if (bus.tick_req !== exp_req || bus.tick_cnt !== exp_cnt || bus.miss_cnt !== MISS_W'(0)) begin
            n_err++;
            $display("FAIL pause k=%0d req=%b cnt=%0d miss=%0d exp=%b/%0d/0",
                     k, bus.tick_req, bus.tick_cnt, bus.miss_cnt, exp_req, exp_cnt);
         end
         bus.clr      = 1'b0;
         bus.pause    = (k >= 3) && (k <= 8);
         bus.tick_ack = (k == 7);
      end
      bus.enable = 1'b0;
      tick();
      n_vec++;
      if (bus.tick_req !== 1'b0) begin
         n_err++;
         $display("FAIL disable_drop req=%b required 0", bus.tick_req);
      end
      repeat (2) tick();
      n_vec++;
      if (bus.tick_req !== 1'b0 || bus.tick_cnt !== CNT_W'(2) || bus.miss_cnt !== MISS_W'(0)) begin
         n_err++;
         $display("FAIL disable_idle req=%b cnt=%0d miss=%0d required 0/2/0",
                  bus.tick_req, bus.tick_cnt, bus.miss_cnt);
      end
   endtask

   // 301 rises without ack (300 misses), then clr vs rise, then async reset mid-PEND.
   task automatic test_miss_count_clr_rst();
      logic [MISS_W-1:0] exp_515;
      logic [MISS_W-1:0] exp_fin;
`ifdef TICK_MISS_SAT_EN
      exp_515 = MISS_W'(255);
      exp_fin = MISS_W'(255);
`else
      exp_515 = MISS_W'(0);
      exp_fin = MISS_W'(44);
`endif
      bus.clkdiv = '0; bus.tap_sel = SEL_W'(0); bus.enable = 1'b1; bus.pause = 1'b0;
      bus.clr = 1'b1; bus.tick_ack = 1'b0;
      for (int k = 0; k <= 603; k++) begin
         tick();
         if (k == 0) bus.clr = 1'b0;
         if (k == 513) begin
            n_vec++;
            if (bus.miss_cnt !== MISS_W'(255)) begin
               n_err++;
               $display("FAIL miss_255 got=%0d required 255", bus.miss_cnt);
            end
         end
         if (k == 515) begin
            n_vec++;
            if (bus.miss_cnt !== exp_515) begin
               n_err++;
               $display("FAIL miss_256th got=%0d required %0d", bus.miss_cnt, exp_515);
            end
         end
      end
      n_vec++;
      if (bus.tick_req !== 1'b1 || bus.tick_cnt !== CNT_W'(301) || bus.miss_cnt !== exp_fin) begin
         n_err++;
         $display("FAIL miss_300 req=%b cnt=%0d miss=%0d required 1/301/%0d",
                  bus.tick_req, bus.tick_cnt, bus.miss_cnt, exp_fin);
      end
      bus.clr = 1'b1;
      repeat (2) tick();
      bus.clr = 1'b0;
      n_vec++;
      if (bus.tick_req !== 1'b1 || bus.tick_cnt !== CNT_W'(0) || bus.miss_cnt !== MISS_W'(0)) begin
         n_err++;
         $display("FAIL clr_wins req=%b cnt=%0d miss=%0d required 1/0/0",
                  bus.tick_req, bus.tick_cnt, bus.miss_cnt);
      end
      repeat (2) tick();
      n_vec++;
      if (bus.tick_cnt !== CNT_W'(1) || bus.miss_cnt !== MISS_W'(1)) begin
         n_err++;
         $display("FAIL post_clr cnt=%0d miss=%0d required 1/1", bus.tick_cnt, bus.miss_cnt);
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (bus.tick_req !== 1'b0 || bus.tick_cnt !== CNT_W'(0) || bus.miss_cnt !== MISS_W'(0)) begin
         n_err++;
         $display("FAIL async_rst req=%b cnt=%0d miss=%0d required 0/0/0",
                  bus.tick_req, bus.tick_cnt, bus.miss_cnt);
      end
      #1 rst = 1'b0;
      tick();
      n_vec++;
      if (bus.tick_req !== 1'b0) begin
         n_err++;
         $display("FAIL after_rst req=%b required 0", bus.tick_req);
      end
   endtask

   initial begin
      test_reset();
      test_tick_stream();
      test_miss_hold();
      test_ack_on_rise();
      test_sel_change();
      test_pause_enable();
      test_miss_count_clr_rst();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
